mini_alu_16bit_sm_acc: RTL and testbench
========================================

Name: mini_alu_16bit_sm_acc

Overview:
Consumer at the far end of the 16-bit subtractor's result interface. The subtractor emits unsigned magnitude plus a "negative" flag when data0 < data1. This block decodes that sign-magnitude pair back to two's complement and keeps a saturating signed running sum. It uses a valid/ready handshake on both sides and a 2-stage pipeline with backpressure.

Parameters:
WIDTH, 16, magnitude width of incoming difference
ACC_W, 20, signed accumulator/output width; must be > WIDTH
CNT_W, 8, accepted-sample counter width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush: zero accumulator, counter, sticky flags
in_valid  input  1  sample present
in_ready  output  1  block can accept sample this cycle
in_mag  input  WIDTH  unsigned magnitude (subtractor diff)
in_neg  input  1  1 = negative (subtractor overflow flag)
out_valid  output  1  out_value/out_count hold a new result
out_ready  input  1  downstream consumes result
out_value  output  ACC_W  signed running sum after latest sample
out_count  output  CNT_W  number of samples accumulated, wraps
out_sat  output  1  sticky: saturation occurred since reset/clear

Behaviour:
- Reset (async, rst=1): all registers 0. in_ready=1 on the first clock after rst deasserts. out_valid=0, out_value=0, out_count=0, out_sat=0.
- Input accept: occurs when in_valid && in_ready.
- Stage 1 (decode register s1):
  - Holds the two's-complement value: zero-extend in_mag to ACC_W+1 bits; negate if in_neg.
  - in_neg=1 with in_mag=0 decodes to 0.
- Stage 2 (accumulate/output register):
  - sum = acc + s1 in ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1: clamp to max and set out_sat. Below -2^(ACC_W-1): clamp to min and set out_sat.
  - The accumulator is the out_value register.
- Advance conditions:
  - s1 advances when !out_valid || out_ready.
  - in_ready = !s1_valid || s1 advances. This is combinational from out_ready; no bubble at full throughput.
- Latency: sample accepted in cycle N gives out_valid in cycle N+2 with no backpressure. Throughput is 1 sample/cycle.
- out_valid: set when stage 2 loads. Cleared on out_ready when no new load occurs in the same cycle. out_value/out_count are stable while out_valid && !out_ready.
- out_count increments by 1 per stage-2 load and wraps 2^CNT_W-1 -> 0.
- clear has priority over everything:
  - In the clear cycle, s1 and out_valid are cleared, acc, count and sat go to 0, and in_ready=0, so a simultaneous sample is not accepted.
  - Normal operation resumes the next cycle.
- Reset mid-operation: in-flight samples are discarded and there is no partial output.
- out_sat stays set until rst or clear; later in-range sums do not clear it.

Optional Feature:
MINI_ALU_SM_ACC_NEGZERO_ERR_EN
- Defined:
  - Adds output port err_negzero (1 bit, reset 0).
  - err_negzero is a sticky flag set when an accepted sample has in_neg=1 and in_mag=0. The subtractor never produces that encoding, so it is illegal.
  - The sample still decodes to 0 and is counted.
  - Cleared by rst/clear.
- Undefined: port absent; the encoding silently decodes to 0.

Decomposition:
- Shared package mini_alu_pkg holds:
  - WIDTH/ACC_W/CNT_W defaults.
  - ACC_MAX/ACC_MIN constants derived from ACC_W.
  - A saturate function (ACC_W+1 -> ACC_W plus sat bit), reusable by future ALU accumulators.
- One natural sub-module: mini_alu_sm_decode. It is combinational: in_mag, in_neg -> ACC_W+1 signed value, plus a negzero indication.
- Handshake, pipeline registers and accumulator stay in the top.

Test Plan:
- Reset: assert rst mid-stream with 2 samples in flight -> out_valid=0, out_value=0, out_count=0, out_sat=0 immediately. in_ready=1 after release.
- Decode/latency: (mag=5,neg=0) at cycle 0, (mag=3,neg=1) at cycle 1, out_ready=1 -> out_valid cycles 2 and 3 with out_value 5 then 2, out_count 1 then 2.
- Saturation: 9 samples (0xFFFF,neg=0) -> after 8, out_value=524280; after 9th, 524287 and out_sat=1. Then (0xFFFF,neg=1) -> 458752, out_sat stays 1.
- Backpressure: out_ready=0, offer 3 back-to-back samples 1,2,3 -> only 2 accepted, in_ready=0, out_value=1 held stable. Raise out_ready -> outputs 1,3,6 in order, no loss or duplication.
- Clear collision: acc=100, assert clear with in_valid=1 (mag=7) -> in_ready=0, sample not accepted, next cycle out_value=0, out_count=0, out_sat=0, out_valid=0. A following 7 gives 7.
- Counter wrap and negzero (CNT_W=8, macro defined): 256 samples of (0,neg=0) -> out_count wraps 255 -> 0. Then (mag=0,neg=1) -> err_negzero=1, out_value unchanged, out_count=1.

Source files
------------

// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg: shared defaults, accumulator limits and the saturation helper
// for the mini ALU accumulators.
package mini_alu_pkg;

    localparam int WIDTH_DEF = 16;   // magnitude width of the incoming difference
    localparam int ACC_W_DEF = 20;   // signed accumulator width, must exceed WIDTH
    localparam int CNT_W_DEF = 8;    // accepted-sample counter width

    // Limits of the default-width accumulator
    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // The helper works on a wide signed carrier so any accumulator up to
    // 63 bits can reuse it; the caller truncates the result to its width.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] value;
    } sat_result_t;

    // Clamp a sign-extended (acc_w+1)-bit sum into the signed acc_w-bit range
    // and report whether clamping happened.
    function automatic sat_result_t saturate(input logic signed [SAT_W-1:0] sum,
                                             input int unsigned             acc_w);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_result_t             res;
        max_v     = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        min_v     = -max_v - 64'sd1;
        res.sat   = 1'b0;
        res.value = sum;
        if (sum > max_v) begin
            res.sat   = 1'b1;
            res.value = max_v;
        end else if (sum < min_v) begin
            res.sat   = 1'b1;
            res.value = min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/mini_alu_sm_decode.sv
// mini_alu_sm_decode: sign-magnitude to two's complement conversion of the
// subtractor result. Purely combinational. negzero flags the "-0" pattern,
// which the subtractor never emits.
module mini_alu_sm_decode
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [WIDTH-1:0]  in_mag,
    input  logic              in_neg,
    output logic signed [ACC_W:0] value,
    output logic              negzero
);

    logic signed [ACC_W:0] mag_ext;

    // Zero-extend the magnitude one bit past the accumulator, then apply the sign
    always_comb begin
        mag_ext = {{(ACC_W + 1 - WIDTH){1'b0}}, in_mag};
        negzero = in_neg && (in_mag == '0);
        value   = in_neg ? -mag_ext : mag_ext;
    end

endmodule

// File: rtl/mini_alu_16bit_sm_acc.sv
// mini_alu_16bit_sm_acc: saturating signed running sum of sign-magnitude
// subtractor results. Two pipeline stages (decode register, accumulator /
// output register) with valid/ready on both sides and full-rate throughput.
// Optional build macro MINI_ALU_SM_ACC_NEGZERO_ERR_EN adds the sticky
// err_negzero output for the illegal "-0" encoding.
module mini_alu_16bit_sm_acc
    import mini_alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mag,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_value,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
`ifdef MINI_ALU_SM_ACC_NEGZERO_ERR_EN
    ,
    output logic             err_negzero
`endif
);

    // Stage 1 (decoded sample) and stage 2 (accumulator / output) state
    logic                    s1_valid_reg;
    logic signed [ACC_W:0]   s1_value_reg;
    logic                    out_valid_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    sat_reg;

    logic signed [ACC_W:0]   dec_value;
    logic                    dec_negzero;
    logic signed [ACC_W:0]   s1_load_value;
    logic                    s1_advance;
    logic                    accept;
    logic                    s2_load;
    logic signed [ACC_W:0]   sum_next;
    logic signed [SAT_W-1:0] sum_wide;
    sat_result_t             sat_res;
    logic signed [ACC_W-1:0] acc_next;

    mini_alu_sm_decode #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_decode (
        .in_mag  (in_mag),
        .in_neg  (in_neg),
        .value   (dec_value),
        .negzero (dec_negzero)
    );

    // Handshake: stage 1 drains whenever the output slot is free or being read,
    // so in_ready follows out_ready combinationally and no bubble is inserted.
    // clear blocks acceptance so a colliding sample is dropped, not half-loaded.
    always_comb begin
        s1_advance    = !out_valid_reg || out_ready;
        in_ready      = !clear && (!s1_valid_reg || s1_advance);
        accept        = in_valid && in_ready;
        s2_load       = s1_valid_reg && s1_advance;
        // The illegal -0 pattern is pinned to +0 regardless of how it decodes
        s1_load_value = dec_negzero ? '0 : dec_value;
    end

    // Accumulate one bit wider than the accumulator, then clamp back into range
    always_comb begin
        sum_next = {acc_reg[ACC_W-1], acc_reg} + s1_value_reg;
        sum_wide = {{(SAT_W - ACC_W - 1){sum_next[ACC_W]}}, sum_next};
        sat_res  = saturate(sum_wide, ACC_W);
        acc_next = ACC_W'(sat_res.value);
    end

    // Stage 1 register: load on accept, empty when its sample moves on unreplaced
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_value_reg <= '0;
        end else if (clear) begin
            s1_valid_reg <= 1'b0;
            s1_value_reg <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_value_reg <= s1_load_value;
        end else if (s2_load) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage 2 register: accumulator doubles as the held output value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            count_reg     <= '0;
            sat_reg       <= 1'b0;
        end else if (clear) begin
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
            count_reg     <= '0;
            sat_reg       <= 1'b0;
        end else if (s2_load) begin
            out_valid_reg <= 1'b1;
            acc_reg       <= acc_next;
            count_reg     <= count_reg + CNT_W'(1);
            sat_reg       <= sat_reg | sat_res.sat;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef MINI_ALU_SM_ACC_NEGZERO_ERR_EN
    logic negzero_reg;

    // Sticky record of an accepted -0 sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            negzero_reg <= 1'b0;
        end else if (clear) begin
            negzero_reg <= 1'b0;
        end else if (accept && dec_negzero) begin
            negzero_reg <= 1'b1;
        end
    end

    assign err_negzero = negzero_reg;
`endif

    assign out_valid = out_valid_reg;
    assign out_value = acc_reg;
    assign out_count = count_reg;
    assign out_sat   = sat_reg;

endmodule

// File: tb/tb_mini_alu_16bit_sm_acc.sv
// Testbench for mini_alu_16bit_sm_acc: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_mini_alu_16bit_sm_acc;

    localparam int ACC_MAX_I = (1 << 19) - 1;
    localparam int ACC_MIN_I = -(1 << 19);

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mag;
    logic        in_neg;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_value;
    logic [7:0]  out_count;
    logic        out_sat;
`ifdef MINI_ALU_SM_ACC_NEGZERO_ERR_EN
    logic        err_negzero;
`endif

    mini_alu_16bit_sm_acc dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_neg    (in_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_count (out_count),
        .out_sat   (out_sat)
`ifdef MINI_ALU_SM_ACC_NEGZERO_ERR_EN
        ,
        .err_negzero (err_negzero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each accepted sample becomes one expected result,
    // tagged with its accept cycle. The block holds at most two samples;
    // a result is visible two cycles after acceptance unless an older one
    // is still waiting to be consumed.
    typedef struct {
        int cyc;
        int acc;
        int cnt;
        bit sat;
    } exp_t;

    exp_t pend_q[$];
    int   m_acc, m_cnt;
    bit   m_sat, m_err;
    int   last_acc, last_cnt;
    bit   last_sat;
    bit   last_accept;
    int   cyc;
    int   checks;
    int   failures;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic flush_model();
        pend_q.delete();
        m_acc    = 0;
        m_cnt    = 0;
        m_sat    = 0;
        m_err    = 0;
        last_acc = 0;
        last_cnt = 0;
        last_sat = 0;
    endtask

    task automatic model_accept(input int mag, input bit neg);
        int   s;
        exp_t e;
        s = m_acc + (neg ? -mag : mag);
        if (s > ACC_MAX_I) begin
            s     = ACC_MAX_I;
            m_sat = 1;
        end else if (s < ACC_MIN_I) begin
            s     = ACC_MIN_I;
            m_sat = 1;
        end
        m_acc = s;
        m_cnt = (m_cnt + 1) % 256;
        if (neg && mag == 0) m_err = 1;
        e.cyc = cyc;
        e.acc = m_acc;
        e.cnt = m_cnt;
        e.sat = m_sat;
        pend_q.push_back(e);
    endtask

    // One clock cycle: inputs are already set (at the falling edge); check all
    // outputs against the model, update the model, advance to the next fall.
    task automatic tick();
        bit exp_ready, exp_valid, acc_now, fire;
        int e_acc, e_cnt;
        bit e_sat;
        #1;
        exp_ready = !clear && (pend_q.size() < 2 || out_ready);
        exp_valid = 0;
        if (pend_q.size() > 0) exp_valid = (pend_q[0].cyc <= cyc - 2);
        if (exp_valid) begin
            e_acc = pend_q[0].acc;
            e_cnt = pend_q[0].cnt;
            e_sat = pend_q[0].sat;
        end else begin
            e_acc = last_acc;
            e_cnt = last_cnt;
            e_sat = last_sat;
        end
        chk("in_ready",  in_ready,          exp_ready);
        chk("out_valid", out_valid,         exp_valid);
        chk("out_value", $signed(out_value), e_acc);
        chk("out_count", out_count,         e_cnt);
        chk("out_sat",   out_sat,           e_sat);
`ifdef MINI_ALU_SM_ACC_NEGZERO_ERR_EN
        chk("err_negzero", err_negzero, m_err);
`endif
        acc_now     = in_valid && exp_ready;
        fire        = exp_valid && out_ready;
        last_accept = acc_now;
        if (clear) begin
            flush_model();
        end else begin
            if (fire) begin
                last_acc = pend_q[0].acc;
                last_cnt = pend_q[0].cnt;
                last_sat = pend_q[0].sat;
                void'(pend_q.pop_front());
            end
            if (acc_now) model_accept(int'(in_mag), in_neg);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_value", $signed(out_value), 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_sat",   out_sat, 0);
        flush_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Offer one sample until the model says it was taken (bounded)
    task automatic send(input logic [15:0] mag, input logic neg);
        bit done;
        in_valid = 1'b1;
        in_mag   = mag;
        in_neg   = neg;
        done     = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            tick();
            done = last_accept;
        end
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_mag   = '0;
        in_neg   = 1'b0;
        out_ready = 1'b1;
        flush_model();
        @(negedge clk);
        do_reset();

        // Decode and two-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_mag = 16'd5; in_neg = 1'b0; tick();
        in_mag = 16'd3; in_neg = 1'b1; tick();
        in_valid = 1'b0;
        chk("lat_valid_c2", out_valid, 1);
        chk("lat_value_c2", $signed(out_value), 5);
        chk("lat_count_c2", out_count, 1);
        tick();
        chk("lat_value_c3", $signed(out_value), 2);
        chk("lat_count_c3", out_count, 2);
        idle(2);

        // Positive saturation and stickiness
        do_clear();
        repeat (9) send(16'hFFFF, 1'b0);
        chk("sat_after8", $signed(out_value), 524280);
        chk("sat_flag_after8", out_sat, 0);
        send(16'hFFFF, 1'b1);
        chk("sat_after9", $signed(out_value), 524287);
        chk("sat_flag_after9", out_sat, 1);
        idle(3);
        chk("sat_after_neg", $signed(out_value), 458752);
        chk("sat_sticky", out_sat, 1);
        chk("sat_count", out_count, 10);

        // Backpressure: three offered, two taken, output held
        do_clear();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mag = 16'd1; in_neg = 1'b0; tick();
        in_mag = 16'd2; tick();
        in_mag = 16'd3; tick();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_value", $signed(out_value), 1);
        tick(); tick();
        chk("bp_value_held", $signed(out_value), 1);
        chk("bp_valid_held", out_valid, 1);
        out_ready = 1'b1;
        send(16'd3, 1'b0);
        idle(4);
        chk("bp_final_value", $signed(out_value), 6);
        chk("bp_final_count", out_count, 3);

        // Reset with two samples in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_mag = 16'd9; in_neg = 1'b0; tick();
        in_mag = 16'd4; tick();
        in_valid = 1'b0;
        do_reset();
        out_ready = 1'b1;
        chk("rst_in_ready", in_ready, 1);
        idle(3);

        // Clear colliding with an offered sample
        send(16'd100, 1'b0);
        idle(3);
        chk("clr_pre_value", $signed(out_value), 100);
        clear = 1'b1; in_valid = 1'b1; in_mag = 16'd7; in_neg = 1'b0;
        #1;
        chk("clr_in_ready", in_ready, 0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_value", $signed(out_value), 0);
        chk("clr_count", out_count, 0);
        chk("clr_sat", out_sat, 0);
        chk("clr_valid", out_valid, 0);
        send(16'd7, 1'b0);
        idle(3);
        chk("clr_next_value", $signed(out_value), 7);
        chk("clr_next_count", out_count, 1);

        // Counter wrap and the -0 encoding
        do_clear();
        repeat (256) send(16'd0, 1'b0);
        idle(3);
        chk("wrap_count", out_count, 0);
        chk("wrap_value", $signed(out_value), 0);
        send(16'd0, 1'b1);
        idle(3);
        chk("negzero_count", out_count, 1);
        chk("negzero_value", $signed(out_value), 0);
`ifdef MINI_ALU_SM_ACC_NEGZERO_ERR_EN
        chk("negzero_err", err_negzero, 1);
`endif

        // Random traffic: mostly-positive then mostly-negative drift
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_mag    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) in_mag = 16'hFFFF - 16'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) in_mag = 16'd0;
            in_neg    = (i < 1500) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 199) == 0);
            tick();
        end
        clear     = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
